// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and default latencies.
package md_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MADD  = 3'd5;
    localparam logic [2:0] MD_MTHI  = 3'd6;
    localparam logic [2:0] MD_MTLO  = 3'd7;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) ||
               (op == MD_DIVU) || (op == MD_MADD);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_arith.sv
// Combinational datapath for the md unit: multiply, multiply-add and divide results.
module md_arith
    import md_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] w_uprod;
    logic [63:0] w_sprod;
    logic [63:0] w_madd;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_squo;
    logic [31:0] w_srem;
    logic [31:0] w_uquo;
    logic [31:0] w_urem;
    logic        w_div0;

    // Low 64 bits of the product of sign-extended operands give the signed product.
    assign w_uprod = {32'b0, rs} * {32'b0, rt};
    assign w_sprod = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign w_madd  = {hi, lo} + w_sprod;

    // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign w_abs_a = rs[31] ? (~rs + 32'd1) : rs;
    assign w_abs_b = rt[31] ? (~rt + 32'd1) : rt;
    assign w_div0  = (rt == 32'd0);

    always_comb begin
        w_squo = 32'd0;
        w_srem = 32'd0;
        w_uquo = 32'd0;
        w_urem = 32'd0;
        if (!w_div0) begin
            w_uquo = rs / rt;
            w_urem = rs % rt;
            w_squo = w_abs_a / w_abs_b;
            w_srem = w_abs_a % w_abs_b;
            if (rs[31] ^ rt[31]) w_squo = ~w_squo + 32'd1;
            if (rs[31])          w_srem = ~w_srem + 32'd1;
        end
    end

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op)
            MD_MULT:  {res_hi, res_lo} = w_sprod;
            MD_MULTU: {res_hi, res_lo} = w_uprod;
            MD_MADD:  {res_hi, res_lo} = w_madd;
            MD_DIV:   if (!w_div0) begin
                          res_hi = w_srem;
                          res_lo = w_squo;
                      end
            MD_DIVU:  if (!w_div0) begin
                          res_hi = w_urem;
                          res_lo = w_uquo;
                      end
            default:  ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide sequencer: busy down-counter, pending result registers and HI/LO.
//  state  | meaning
//  IDLE   | accepts mult/div/madd (goes BUSY) or mthi/mtlo (single cycle)
//  BUSY   | counting down; commits pending result to HI/LO when cnt reaches 1
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        md_wait,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] C_MULT = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] C_DIV  = CNT_W'(DIV_CYC);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_arith;

    assign w_arith = is_arith(md_op);

    md_arith u_arith (
        .op     (md_op),
        .rs     (rs_val),
        .rt     (rt_val),
        .hi     (r_hi),
        .lo     (r_lo),
        .res_hi (w_res_hi),
        .res_lo (w_res_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_arith) begin
                        r_pend_hi <= w_res_hi;
                        r_pend_lo <= w_res_lo;
                        r_cnt     <= is_div(md_op) ? C_DIV : C_MULT;
                        r_state   <= S_BUSY;
                        r_busy    <= 1'b1;
                    end else if (start && md_op == MD_MTHI) begin
                        r_hi <= rs_val;
                    end else if (start && md_op == MD_MTLO) begin
                        r_lo <= rs_val;
                    end
                end
                S_BUSY: begin
                    // Starts while busy are dropped; the hazard unit keeps them away.
                    r_cnt <= r_cnt - C_ONE;
                    if (r_cnt == C_ONE) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign md_wait = r_busy | (start & w_arith);
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit; inputs driven and outputs sampled on falling edges.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        md_wait;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .busy    (busy),
        .md_wait (md_wait),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the first busy cycle.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        #1;
        chk({tag, "_md_wait"}, {31'b0, md_wait}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
    endtask

    // Counts busy cycles from the current falling edge; stops at the first idle one.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic mtx(input logic [2:0] op, input logic [31:0] a, input string tag);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        #1;
        chk({tag, "_md_wait"}, {31'b0, md_wait}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        md_op  = MD_NONE;
        rs_val = 32'd0;
        rt_val = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_wait", {31'b0, md_wait}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // 1: signed mult -3 * 5
        issue(MD_MULT, 32'hFFFFFFFD, 32'd5, "t1");
        wait_idle(n);
        chk("t1_busy_len", n, 32'd5);
        chk("t1_hi", hi, 32'hFFFFFFFF);
        chk("t1_lo", lo, 32'hFFFFFFF1);

        // 2: multu, then back-to-back multu in the first idle cycle
        issue(MD_MULTU, 32'hFFFFFFFF, 32'd2, "t2a");
        chk("t2a_hold_hi", hi, 32'hFFFFFFFF);
        wait_idle(n);
        chk("t2a_busy_len", n, 32'd5);
        chk("t2a_hi", hi, 32'h00000001);
        chk("t2a_lo", lo, 32'hFFFFFFFE);
        issue(MD_MULTU, 32'd3, 32'd3, "t2b");
        wait_idle(n);
        chk("t2b_busy_len", n, 32'd5);
        chk("t2b_hi", hi, 32'd0);
        chk("t2b_lo", lo, 32'd9);

        // 3: signed div -7/2, divu by zero, and the overflow case
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, "t3a");
        wait_idle(n);
        chk("t3a_busy_len", n, 32'd10);
        chk("t3a_hi", hi, 32'hFFFFFFFF);
        chk("t3a_lo", lo, 32'hFFFFFFFD);
        issue(MD_DIVU, 32'd7, 32'd0, "t3b");
        wait_idle(n);
        chk("t3b_busy_len", n, 32'd10);
        chk("t3b_hi", hi, 32'hFFFFFFFF);
        chk("t3b_lo", lo, 32'hFFFFFFFD);
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, "t3c");
        wait_idle(n);
        chk("t3c_busy_len", n, 32'd10);
        chk("t3c_hi", hi, 32'd0);
        chk("t3c_lo", lo, 32'h80000000);
        issue(MD_DIV, 32'd100, 32'hFFFFFFF9, "t3d");
        wait_idle(n);
        chk("t3d_hi", hi, 32'd2);
        chk("t3d_lo", lo, 32'hFFFFFFF2);

        // 4: mthi, then a start during busy is ignored
        mtx(MD_MTHI, 32'h12345678, "t4m");
        chk("t4m_hi", hi, 32'h12345678);
        chk("t4m_lo", lo, 32'hFFFFFFF2);
        issue(MD_MULT, 32'd2, 32'd3, "t4a");
        start  = 1'b1;
        md_op  = MD_MULT;
        rs_val = 32'd9;
        rt_val = 32'd9;
        #1;
        chk("t4_wait_busy", {31'b0, md_wait}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        wait_idle(n);
        chk("t4_busy_len", n + 1, 32'd5);
        chk("t4_hi", hi, 32'd0);
        chk("t4_lo", lo, 32'd6);
        repeat (6) @(negedge clk);
        chk("t4_no_second", lo, 32'd6);
        chk("t4_idle", {31'b0, busy}, 32'd0);

        // 5: mtlo/mthi seed then madd accumulations
        mtx(MD_MTLO, 32'h10, "t5l");
        mtx(MD_MTHI, 32'h0, "t5h");
        chk("t5_seed_lo", lo, 32'h10);
        issue(MD_MADD, 32'd3, 32'd4, "t5a");
        wait_idle(n);
        chk("t5a_busy_len", n, 32'd5);
        chk("t5a_hi", hi, 32'd0);
        chk("t5a_lo", lo, 32'h1C);
        issue(MD_MADD, 32'hFFFFFFFF, 32'd1, "t5b");
        wait_idle(n);
        chk("t5b_hi", hi, 32'd0);
        chk("t5b_lo", lo, 32'h1B);

        // 6: reset on busy cycle 4 discards the in-flight divide
        issue(MD_DIV, 32'd100, 32'd7, "t6");
        repeat (3) @(negedge clk);
        chk("t6_busy_c4", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_hi", hi, 32'd0);
        chk("t6_lo", lo, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_nocommit_lo", lo, 32'd0);
            chk("t6_nocommit_hi", hi, 32'd0);
            chk("t6_nocommit_busy", {31'b0, busy}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
